// File: rtl/l1_snooper.sv
// l1_snooper: per-core snoop responder for the coherence bus.
// Takes one bus snoop and looks it up in the local L1 tag array. One cycle
// later it answers with shared plus the line data, then applies the MESI
// downgrade or invalidate.
// Optional build macro: L1_SNOOP_STATS_EN adds saturating snoop/hit/inval counters.

`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 6
`endif
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 512
`endif

package cache_pkg;
  typedef enum logic [1:0] {
    BUS_RD   = 2'd0,
    BUS_RDX  = 2'd1,
    BUS_UPGR = 2'd2,
    BUS_WB   = 2'd3
  } bus_req_t;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;
endpackage

module l1_snooper
  import cache_pkg::*;
#(
  parameter int unsigned WAYS    = 4,
  parameter int unsigned LINE_AW = `ADDR_BITS - `OFFSET_BITS,
  localparam int unsigned WB     = $clog2(WAYS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       snoop_valid,
  input  logic [LINE_AW-1:0]         snoop_addr,
  input  bus_req_t                   snoop_req,
  output logic                       snoop_shared,
  output logic [`CACHELINE_BITS-1:0] snoop_data,
  output logic [LINE_AW-1:0]         tag_lookup_addr,
  input  logic                       tag_hit,
  input  logic [WB-1:0]              tag_hit_way,
  input  logic [1:0]                 tag_hit_state,
  output logic                       data_rd_en,
  output logic [LINE_AW-1:0]         data_rd_addr,
  output logic [WB-1:0]              data_rd_way,
  input  logic [`CACHELINE_BITS-1:0] data_rd_data,
  output logic                       state_wr_en,
  output logic [LINE_AW-1:0]         state_wr_addr,
  output logic [WB-1:0]              state_wr_way,
  output logic [1:0]                 state_wr_state,
  output logic                       snoop_busy,
  output logic                       inval_valid,
  output logic [LINE_AW-1:0]         inval_addr
`ifdef L1_SNOOP_STATS_EN
  ,
  output logic [31:0]                stat_snoops,
  output logic [31:0]                stat_hits,
  output logic [31:0]                stat_invals
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t            state_q, state_d;
  bus_req_t          cap_req;
  logic [LINE_AW-1:0] cap_addr;
  logic              cap_hit;
  logic [WB-1:0]     cap_way;
  mesi_t             cap_state;

  logic  present;
  mesi_t new_state;

  // State register and snoop capture; a snoop is only accepted from IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cap_req   <= BUS_RD;
      cap_addr  <= '0;
      cap_hit   <= 1'b0;
      cap_way   <= '0;
      cap_state <= MESI_I;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && snoop_valid) begin
        cap_req   <= snoop_req;
        cap_addr  <= snoop_addr;
        cap_hit   <= tag_hit;
        cap_way   <= tag_hit_way;
        cap_state <= mesi_t'(tag_hit_state);
      end
    end
  end

  // Next state, array requests and response; reset gates every output to 0
  always_comb begin
    state_d         = state_q;
    present         = 1'b0;
    new_state       = MESI_I;
    snoop_shared    = 1'b0;
    snoop_data      = '0;
    tag_lookup_addr = '0;
    data_rd_en      = 1'b0;
    data_rd_addr    = '0;
    data_rd_way     = '0;
    state_wr_en     = 1'b0;
    state_wr_addr   = '0;
    state_wr_way    = '0;
    state_wr_state  = '0;
    snoop_busy      = 1'b0;
    inval_valid     = 1'b0;
    inval_addr      = '0;
    if (reset_n) begin
      unique case (state_q)
        IDLE: begin
          tag_lookup_addr = snoop_addr;
          snoop_busy      = snoop_valid;
          if (snoop_valid) begin
            state_d = RESP;
            if (tag_hit && (snoop_req == BUS_RD || snoop_req == BUS_RDX)) begin
              data_rd_en   = 1'b1;
              data_rd_addr = snoop_addr;
              data_rd_way  = tag_hit_way;
            end
          end
        end
        RESP: begin
          state_d      = IDLE;
          snoop_busy   = 1'b1;
          present      = cap_hit && (cap_state != MESI_I);
          snoop_shared = present && (cap_req == BUS_RD || cap_req == BUS_RDX);
          if (snoop_shared) snoop_data = data_rd_data;
          if (present) begin
            unique case (cap_req)
              BUS_RD: begin
                // S stays S without a write; only E/M are downgraded
                if (cap_state == MESI_E || cap_state == MESI_M) begin
                  state_wr_en = 1'b1;
                  new_state   = MESI_S;
                end
              end
              BUS_RDX, BUS_UPGR: begin
                // UPGR against E/M is a protocol error; the line is dropped anyway
                state_wr_en = 1'b1;
                new_state   = MESI_I;
              end
              default: ;
            endcase
          end
          if (state_wr_en) begin
            state_wr_addr  = cap_addr;
            state_wr_way   = cap_way;
            state_wr_state = new_state;
            if (new_state == MESI_I) begin
              inval_valid = 1'b1;
              inval_addr  = cap_addr;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef L1_SNOOP_STATS_EN
  // Saturating event counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_snoops <= '0;
      stat_hits   <= '0;
      stat_invals <= '0;
    end else begin
      if (state_q == IDLE && snoop_valid && stat_snoops != '1) stat_snoops <= stat_snoops + 32'd1;
      if (snoop_shared && stat_hits != '1) stat_hits <= stat_hits + 32'd1;
      if (inval_valid && stat_invals != '1) stat_invals <= stat_invals + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_snoop_in_resp: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == RESP) |-> !snoop_valid);
`endif

endmodule
